instr_fetch: RTL

Front-end pipeline stage that produces the `fetched` decoupled stream consumed by instruction decode. It holds the program counter and issues word-aligned reads to the instruction memory port, one request outstanding at a time. Returned instruction words are paired with their PC and buffered in a small FIFO. A flush redirects the PC, empties the buffer and discards any in-flight response.

---
 rtl/instr_fetch.sv | 71 +++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: program counter and single-outstanding instruction read port,
// feeding a small {pc, raw} FIFO toward decode; flush redirects and drops in-flight data.
module instr_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetched_valid,
  input  logic        fetched_ready,
  output logic [63:0] fetched_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        flush,
  input  logic [31:0] flush_target
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
  state_t state, state_nxt;
  logic [31:0] pc, req_pc;
  logic [63:0] fifo [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic req_fire, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // a slot is effectively reserved at issue: count only grows via this one outstanding response
  always_comb begin
    mem_req_valid = state == S_REQ && count != FULL && !flush && rst;
    mem_req_addr = pc;
    req_fire = mem_req_valid && mem_req_ready;
    fetched_valid = count != '0 && rst;
    fetched_data = fifo[head];
    push = state == S_WAIT && mem_resp_valid && !flush;
    pop = fetched_valid && fetched_ready && !flush;
    state_nxt = flush ? ((state == S_REQ || mem_resp_valid) ? S_REQ : S_DROP)
              : state == S_REQ ? (req_fire ? S_WAIT : S_REQ)
              : mem_resp_valid ? S_REQ : state;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_REQ;
      pc <= RESET_VEC;
      req_pc <= RESET_VEC;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      pc <= flush ? {flush_target[31:2], 2'b00} : req_fire ? pc + 32'd4 : pc;
      if (req_fire) req_pc <= pc;
      if (flush) begin
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        if (push) tail <= nxt(tail);
        if (pop) head <= nxt(head);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) if (push) fifo[tail] <= {req_pc, mem_resp_data};
  a_no_resp_in_req: assert property (@(posedge clk) disable iff (!rst) !(state == S_REQ && mem_resp_valid));
endmodule
